// File: rtl/clint_pkg.sv
// Shared constants, FSM state type and address-decode helper for the CLINT
// request arbiter.
package clint_pkg;

  // CLINT register map bases (offsets within the 64 KiB CLINT window).
  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

  // Register widths per core, in bytes.
  localparam int unsigned MSIP_BYTES     = 4;
  localparam int unsigned MTIMECMP_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } clint_state_e;

  // Legal offsets: msip block, mtimecmp block, and the single mtime address.
  // MSIP_BASE is zero, so the msip range only needs an upper bound; the
  // 17-bit arithmetic keeps the range ends from wrapping for large core counts.
  function automatic logic clint_addr_legal(input logic [15:0] a,
                                            input int unsigned nr_cores);
    logic [16:0] ax;
    logic [16:0] msip_end;
    logic [16:0] cmp_lo;
    logic [16:0] cmp_end;
    ax       = {1'b0, a};
    msip_end = {1'b0, MSIP_BASE} + 17'(MSIP_BYTES * nr_cores);
    cmp_lo   = {1'b0, MTIMECMP_BASE};
    cmp_end  = cmp_lo + 17'(MTIMECMP_BYTES * nr_cores);
    return (ax < msip_end) ||
           ((ax >= cmp_lo) && (ax < cmp_end)) ||
           (a == MTIME_BASE);
  endfunction

endpackage

// File: rtl/clint_rr_arb.sv
// Combinational round-robin picker: the first set request at or after the
// pointer (wrapping) wins; returns a one-hot grant and its index.
module clint_rr_arb #(
  parameter int unsigned NR_REQ = 2,
  parameter int unsigned IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic [NR_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NR_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters starting at the pointer; the pointer is always < NR_REQ,
  // so one subtraction is enough to wrap.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if ((32'(ptr_i) + i) >= NR_REQ) begin
        cand = IDX_W'(32'(ptr_i) + i - NR_REQ);
      end else begin
        cand = IDX_W'(32'(ptr_i) + i);
      end
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/clint_req_arbiter.sv
// Shares one CLINT register port between NR_REQ requesters, one transaction
// at a time, with round-robin fairness.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a request; grants one winner combinationally
//   ST_ACCESS | single cycle driving the CLINT port from latched request
//   ST_RESP   | holding the response to the winner until it is accepted
module clint_req_arbiter
  import clint_pkg::*;
#(
  parameter int unsigned NR_REQ         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned NR_CORES       = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NR_REQ-1:0]                        req_valid_i,
  output logic [NR_REQ-1:0]                        req_ready_o,
  input  logic [NR_REQ-1:0][AXI_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NR_REQ-1:0]                        req_we_i,
  input  logic [NR_REQ-1:0][63:0]                  req_wdata_i,
  output logic [NR_REQ-1:0]                        rsp_valid_o,
  input  logic [NR_REQ-1:0]                        rsp_ready_i,
  output logic [63:0]                              rsp_rdata_o,
  output logic                                     rsp_err_o,
  output logic [AXI_ADDR_WIDTH-1:0]                address_o,
  output logic                                     en_o,
  output logic                                     we_o,
  output logic [63:0]                              wdata_o,
  input  logic [63:0]                              data_i
);

  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_REQ - 1);

  clint_state_e state_q, state_d;

  logic [IDX_W-1:0]          rr_q;
  logic [IDX_W-1:0]          idx_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic                      we_q;
  logic [63:0]               wdata_q;
  logic [63:0]               rdata_q;
  logic                      err_q;

  logic [NR_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic              grant;
  logic              addr_ok;

  clint_rr_arb #(
    .NR_REQ (NR_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign addr_ok = clint_addr_legal(addr_q[15:0], NR_CORES);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all handshake / CLINT port outputs.
  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    en_o        = 1'b0;
    we_o        = 1'b0;
    address_o   = '0;
    wdata_o     = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant       = 1'b1;
          req_ready_o = arb_gnt;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        address_o = addr_q;
        we_o      = we_q;
        wdata_o   = wdata_q;
        en_o      = addr_ok;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o[idx_q] = 1'b1;
        if (rsp_ready_i[idx_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the winning request and advance the round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant) begin
      rr_q    <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
      idx_q   <= arb_idx;
      addr_q  <= req_addr_i[arb_idx];
      we_q    <= req_we_i[arb_idx];
      wdata_q <= req_wdata_i[arb_idx];
    end
  end

  // Capture the response during the access cycle; writes and decode errors
  // return zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      rdata_q <= (addr_ok && !we_q) ? data_i : '0;
      err_q   <= !addr_ok;
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
